// File: rtl/cavlc_mb_scheduler.sv
// Macroblock scheduler for the CAVLC block decoder: issues the coded luma 4x4 blocks in order,
// derives each block's nC from its left/top neighbours and exports the edge TotalCoeff values.
module cavlc_mb_scheduler #(
    parameter int TC_W = 5
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Start,
    input  logic [3:0]        CbpLuma,
    input  logic              LeftAvail,
    input  logic              TopAvail,
    input  logic [4*TC_W-1:0] LeftTC,
    input  logic [4*TC_W-1:0] TopTC,
    input  logic              BlockDone,
    input  logic [TC_W-1:0]   TotalCoeff,
    output logic              BlockEnable,
    output logic [3:0]        BlkIdx,
    output logic [4:0]        nC,
    output logic              Busy,
    output logic              MbDone,
    output logic [4*TC_W-1:0] RightTC,
    output logic [4*TC_W-1:0] BottomTC
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, FINISH} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cbp;
    logic                r_left_avail;
    logic                r_top_avail;
    logic [4*TC_W-1:0]   r_left_tc;
    logic [4*TC_W-1:0]   r_top_tc;
    logic [TC_W-1:0]     r_tc [16];
    logic [3:0]          r_blk_idx;
    logic [4:0]          r_nc;
    logic [4*TC_W-1:0]   r_right_tc;
    logic [4*TC_W-1:0]   r_bottom_tc;
    logic                r_empty_hold;

    logic [3:0]          w_first_idx;
    logic [3:0]          w_next_idx;
    logic [3:0]          w_tgt_idx;
    logic                w_is_last;
    logic                w_enable;
    logic                w_mb_done;
    logic                w_left_avail;
    logic                w_top_avail;
    logic [TC_W-1:0]     w_left_arr [4];
    logic [TC_W-1:0]     w_top_arr [4];
    logic [TC_W-1:0]     w_tc_eff [16];
    logic [1:0]          w_x;
    logic [1:0]          w_y;
    logic [1:0]          w_xm1;
    logic [1:0]          w_ym1;
    logic [TC_W-1:0]     w_na;
    logic [TC_W-1:0]     w_nb;
    logic                w_a_ok;
    logic                w_b_ok;
    logic [TC_W:0]       w_sum;
    logic [TC_W+1:0]     w_sum_rnd;
    logic [TC_W-1:0]     w_nc_calc;
    logic [4*TC_W-1:0]   w_right_nxt;
    logic [4*TC_W-1:0]   w_bottom_nxt;

    // Coded blocks come in whole quadrants, so only a quadrant boundary needs a search.
    always_comb begin
        w_first_idx = 4'd0;
        for (int q = 3; q >= 0; q--) begin
            if (CbpLuma[q]) w_first_idx = {2'(q), 2'b00};
        end
        w_next_idx = r_blk_idx + 4'd1;
        w_is_last  = 1'b0;
        if (r_blk_idx[1:0] == 2'd3) begin
            w_is_last = 1'b1;
            for (int q = 3; q >= 0; q--) begin
                if (r_cbp[q] && (q > int'(r_blk_idx[3:2]))) begin
                    w_next_idx = {2'(q), 2'b00};
                    w_is_last  = 1'b0;
                end
            end
        end
    end

    // In IDLE the neighbour context comes straight from the ports (latched on the same edge)
    // and the TC array reads as cleared; in WAIT_DONE the returning TotalCoeff is bypassed.
    always_comb begin
        w_left_avail = (r_state == IDLE) ? LeftAvail : r_left_avail;
        w_top_avail  = (r_state == IDLE) ? TopAvail  : r_top_avail;
        for (int i = 0; i < 4; i++) begin
            w_left_arr[i] = (r_state == IDLE) ? LeftTC[TC_W*i +: TC_W] : r_left_tc[TC_W*i +: TC_W];
            w_top_arr[i]  = (r_state == IDLE) ? TopTC[TC_W*i +: TC_W]  : r_top_tc[TC_W*i +: TC_W];
        end
        for (int i = 0; i < 16; i++) begin
            if (r_state == IDLE)
                w_tc_eff[i] = '0;
            else if ((r_state == WAIT_DONE) && BlockDone && (r_blk_idx == 4'(i)))
                w_tc_eff[i] = TotalCoeff;
            else
                w_tc_eff[i] = r_tc[i];
        end
        w_tgt_idx = (r_state == IDLE) ? w_first_idx : w_next_idx;
    end

    always_comb begin
        w_x    = {w_tgt_idx[2], w_tgt_idx[0]};
        w_y    = {w_tgt_idx[3], w_tgt_idx[1]};
        w_xm1  = w_x - 2'd1;
        w_ym1  = w_y - 2'd1;
        w_a_ok = 1'b1;
        w_b_ok = 1'b1;
        w_na   = '0;
        w_nb   = '0;
        if (w_x == 2'd0) begin
            w_a_ok = w_left_avail;
            w_na   = w_left_arr[w_y];
        end else begin
            w_na   = w_tc_eff[{w_y[1], w_xm1[1], w_y[0], w_xm1[0]}];
        end
        if (w_y == 2'd0) begin
            w_b_ok = w_top_avail;
            w_nb   = w_top_arr[w_x];
        end else begin
            w_nb   = w_tc_eff[{w_ym1[1], w_x[1], w_ym1[0], w_x[0]}];
        end
        w_sum     = {1'b0, w_na} + {1'b0, w_nb};
        w_sum_rnd = {1'b0, w_sum} + {{(TC_W+1){1'b0}}, 1'b1};
        case ({w_a_ok, w_b_ok})
            2'b11:   w_nc_calc = w_sum_rnd[TC_W:1];
            2'b10:   w_nc_calc = w_na;
            2'b01:   w_nc_calc = w_nb;
            default: w_nc_calc = '0;
        endcase
    end

    // Column 3 is idx {y1,1,y0,1}; row 3 is idx {1,x1,1,x0}.
    always_comb begin
        w_right_nxt  = '0;
        w_bottom_nxt = '0;
        for (int j = 0; j < 4; j++) begin
            w_right_nxt[TC_W*j +: TC_W]  = w_tc_eff[4'(8*(j/2) + 5 + 2*(j%2))];
            w_bottom_nxt[TC_W*j +: TC_W] = w_tc_eff[4'(10 + 4*(j/2) + (j%2))];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_enable    = 1'b0;
        w_mb_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) w_state_nxt = (CbpLuma == 4'd0) ? FINISH : ISSUE;
            end
            ISSUE: begin
                w_enable    = 1'b1;
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Block FSM chains on Enable, so it must be low for the whole last block.
                w_enable = !w_is_last;
                if (BlockDone && w_is_last) w_state_nxt = FINISH;
            end
            FINISH: begin
                if (!r_empty_hold) begin
                    w_mb_done   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_cbp        <= '0;
            r_left_avail <= 1'b0;
            r_top_avail  <= 1'b0;
            r_left_tc    <= '0;
            r_top_tc     <= '0;
            r_blk_idx    <= '0;
            r_nc         <= '0;
            r_right_tc   <= '0;
            r_bottom_tc  <= '0;
            r_empty_hold <= 1'b0;
            for (int i = 0; i < 16; i++) r_tc[i] <= '0;
        end else begin
            if ((r_state == IDLE) && Start) begin
                r_cbp        <= CbpLuma;
                r_left_avail <= LeftAvail;
                r_top_avail  <= TopAvail;
                r_left_tc    <= LeftTC;
                r_top_tc     <= TopTC;
                r_empty_hold <= (CbpLuma == 4'd0);
                r_blk_idx    <= w_first_idx;
                r_nc         <= 5'(w_nc_calc);
                for (int i = 0; i < 16; i++) r_tc[i] <= '0;
            end
            if ((r_state == WAIT_DONE) && BlockDone) begin
                r_tc[r_blk_idx] <= TotalCoeff;
                if (!w_is_last) begin
                    r_blk_idx <= w_next_idx;
                    r_nc      <= 5'(w_nc_calc);
                end
            end
            if (r_state == FINISH) r_empty_hold <= 1'b0;
            // An empty macroblock holds FINISH one extra cycle before MbDone.
            if ((w_state_nxt == FINISH) && (r_state != FINISH)) begin
                r_right_tc  <= w_right_nxt;
                r_bottom_tc <= w_bottom_nxt;
            end
        end
    end

    assign BlockEnable = w_enable;
    assign BlkIdx      = r_blk_idx;
    assign nC          = r_nc;
    assign Busy        = (r_state != IDLE);
    assign MbDone      = w_mb_done;
    assign RightTC     = r_right_tc;
    assign BottomTC    = r_bottom_tc;

endmodule

// File: tb/tb_cavlc_mb_scheduler.sv
// Bench for cavlc_mb_scheduler: directed first-block table, full macroblocks checked against a
// raster-grid nC model, empty macroblock, ignored events and asynchronous reset mid-macroblock.
module tb_cavlc_mb_scheduler;
    localparam int TC_W = 5;

    logic              Clk = 1'b0;
    logic              nReset = 1'b0;
    logic              Start = 1'b0;
    logic [3:0]        CbpLuma = '0;
    logic              LeftAvail = 1'b0;
    logic              TopAvail = 1'b0;
    logic [4*TC_W-1:0] LeftTC = '0;
    logic [4*TC_W-1:0] TopTC = '0;
    logic              BlockDone = 1'b0;
    logic [TC_W-1:0]   TotalCoeff = '0;
    logic              BlockEnable;
    logic [3:0]        BlkIdx;
    logic [4:0]        nC;
    logic              Busy;
    logic              MbDone;
    logic [4*TC_W-1:0] RightTC;
    logic [4*TC_W-1:0] BottomTC;

    cavlc_mb_scheduler #(.TC_W(TC_W)) dut (
        .Clk(Clk), .nReset(nReset), .Start(Start), .CbpLuma(CbpLuma),
        .LeftAvail(LeftAvail), .TopAvail(TopAvail), .LeftTC(LeftTC), .TopTC(TopTC),
        .BlockDone(BlockDone), .TotalCoeff(TotalCoeff), .BlockEnable(BlockEnable),
        .BlkIdx(BlkIdx), .nC(nC), .Busy(Busy), .MbDone(MbDone),
        .RightTC(RightTC), .BottomTC(BottomTC)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: TotalCoeff kept on a raster grid m_tc[y][x].
    int m_tc [4][4];

    function automatic int bx(int idx);
        return 2 * ((idx / 4) % 2) + (idx % 2);
    endfunction

    function automatic int by(int idx);
        return 2 * (idx / 8) + ((idx / 2) % 2);
    endfunction

    function automatic int model_nc(int idx, logic la, logic ta, logic [19:0] ltc, logic [19:0] ttc);
        int x = bx(idx);
        int y = by(idx);
        int na, nb;
        bit aa, ab;
        if (x == 0) begin aa = la; na = int'(ltc[TC_W*y +: TC_W]); end
        else        begin aa = 1;  na = m_tc[y][x-1]; end
        if (y == 0) begin ab = ta; nb = int'(ttc[TC_W*x +: TC_W]); end
        else        begin ab = 1;  nb = m_tc[y-1][x]; end
        if (aa && ab) return (na + nb + 1) / 2;
        if (aa) return na;
        if (ab) return nb;
        return 0;
    endfunction

    function automatic logic [19:0] rand_tc20();
        logic [19:0] v;
        for (int i = 0; i < 4; i++) v[TC_W*i +: TC_W] = 5'($urandom_range(0, 16));
        return v;
    endfunction

    // Runs one macroblock as the block FSM would; exp_idx/exp_nc >= 0 adds directed first-block checks.
    task automatic run_mb(input logic [3:0] cbp, input logic la, input logic ta,
                          input logic [19:0] ltc, input logic [19:0] ttc,
                          input bit tc_is_idx, input bit start_on_done,
                          input int exp_idx, input int exp_nc);
        int coded[$];
        logic [19:0] exp_r, exp_b;
        int v, idx;
        for (int i = 0; i < 16; i++) if (cbp[i/4]) coded.push_back(i);
        for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) m_tc[y][x] = 0;
        @(negedge Clk);
        CbpLuma = cbp; LeftAvail = la; TopAvail = ta; LeftTC = ltc; TopTC = ttc; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        // Scramble the context ports: the DUT must use what it latched at Start.
        CbpLuma = 4'($urandom); LeftAvail = 1'($urandom); TopAvail = 1'($urandom);
        LeftTC = rand_tc20(); TopTC = rand_tc20();
        chk("busy_after_start", Busy, 1);
        if (coded.size() == 0) begin
            chk("empty_enable", BlockEnable, 0);
            chk("empty_mbdone_early", MbDone, 0);
            @(negedge Clk);
            chk("empty_enable2", BlockEnable, 0);
        end else begin
            if (exp_idx >= 0) chk("first_idx_tab", BlkIdx, exp_idx);
            if (exp_nc >= 0)  chk("first_nc_tab", nC, exp_nc);
            for (int k = 0; k < coded.size(); k++) begin
                idx = coded[k];
                chk("blk_idx", BlkIdx, idx);
                chk("blk_nc", nC, model_nc(idx, la, ta, ltc, ttc));
                chk("enable", BlockEnable, (k != coded.size() - 1));
                chk("no_mbdone", MbDone, 0);
                repeat ($urandom_range(1, 3)) begin
                    @(negedge Clk);
                    chk("enable_wait", BlockEnable, (k != coded.size() - 1));
                end
                v = tc_is_idx ? idx : $urandom_range(0, 16);
                m_tc[by(idx)][bx(idx)] = v;
                BlockDone = 1'b1;
                TotalCoeff = 5'(v);
                @(negedge Clk);
                BlockDone = 1'b0;
                TotalCoeff = 5'($urandom);
            end
        end
        for (int j = 0; j < 4; j++) begin
            exp_r[TC_W*j +: TC_W] = 5'(m_tc[j][3]);
            exp_b[TC_W*j +: TC_W] = 5'(m_tc[3][j]);
        end
        chk("mbdone", MbDone, 1);
        chk("busy_at_mbdone", Busy, 1);
        chk("enable_at_mbdone", BlockEnable, 0);
        chk("right_tc", RightTC, exp_r);
        chk("bottom_tc", BottomTC, exp_b);
        if (start_on_done) begin
            CbpLuma = 4'hF;
            Start = 1'b1;
        end
        @(negedge Clk);
        Start = 1'b0;
        chk("mbdone_pulse", MbDone, 0);
        chk("busy_after", Busy, 0);
        chk("right_tc_hold", RightTC, exp_r);
    endtask

    typedef struct {
        logic [3:0]  cbp;
        logic        la;
        logic        ta;
        logic [19:0] ltc;
        logic [19:0] ttc;
        int          exp_idx;
        int          exp_nc;
    } vec_t;

    vec_t tab [10];

    task automatic chk_all_zero(input string tag);
        chk({tag, "_enable"}, BlockEnable, 0);
        chk({tag, "_blkidx"}, BlkIdx, 0);
        chk({tag, "_nc"}, nC, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_mbdone"}, MbDone, 0);
        chk({tag, "_right"}, RightTC, 0);
        chk({tag, "_bottom"}, BottomTC, 0);
    endtask

    initial begin
        tab[0] = '{4'hF, 1'b0, 1'b0, 20'h0, 20'h0, 0, 0};
        tab[1] = '{4'hF, 1'b1, 1'b0, {5'd2, 5'd6, 5'd3, 5'd9}, {5'd16, 5'd16, 5'd16, 5'd16}, 0, 9};
        tab[2] = '{4'hF, 1'b1, 1'b1, {5'd1, 5'd1, 5'd1, 5'd7}, {5'd2, 5'd2, 5'd2, 5'd4}, 0, 6};
        tab[3] = '{4'hF, 1'b0, 1'b1, {5'd16, 5'd16, 5'd16, 5'd16}, {5'd0, 5'd0, 5'd0, 5'd16}, 0, 16};
        tab[4] = '{4'b0010, 1'b1, 1'b1, {5'd1, 5'd1, 5'd1, 5'd1}, {5'd0, 5'd5, 5'd0, 5'd0}, 4, 3};
        tab[5] = '{4'b0100, 1'b1, 1'b1, {5'd0, 5'd16, 5'd0, 5'd0}, {5'd9, 5'd9, 5'd9, 5'd9}, 8, 8};
        tab[6] = '{4'b1000, 1'b1, 1'b1, {5'd16, 5'd16, 5'd16, 5'd16}, {5'd16, 5'd16, 5'd16, 5'd16}, 12, 0};
        tab[7] = '{4'b1001, 1'b1, 1'b1, {5'd0, 5'd0, 5'd0, 5'd16}, {5'd0, 5'd0, 5'd0, 5'd16}, 0, 16};
        tab[8] = '{4'hF, 1'b0, 1'b1, {5'd16, 5'd16, 5'd16, 5'd16}, {5'd3, 5'd3, 5'd3, 5'd1}, 0, 1};
        tab[9] = '{4'b1100, 1'b1, 1'b0, {5'd0, 5'd9, 5'd0, 5'd0}, {5'd7, 5'd7, 5'd7, 5'd7}, 8, 5};

        repeat (2) @(negedge Clk);
        chk_all_zero("reset");
        nReset = 1'b1;

        for (int i = 0; i < 10; i++)
            run_mb(tab[i].cbp, tab[i].la, tab[i].ta, tab[i].ltc, tab[i].ttc, 1'b0, 1'b0,
                   tab[i].exp_idx, tab[i].exp_nc);

        // Full MB, no neighbours, block i returns i.
        run_mb(4'hF, 1'b0, 1'b0, 20'h0, 20'h0, 1'b1, 1'b0, 0, 0);
        chk("det_right", RightTC, {5'd15, 5'd13, 5'd7, 5'd5});
        chk("det_bottom", BottomTC, {5'd15, 5'd14, 5'd11, 5'd10});

        run_mb(4'b0101, 1'b1, 1'b1, rand_tc20(), rand_tc20(), 1'b0, 1'b0, 0, -1);

        // Empty MB, with Start held high during MbDone (must be ignored).
        run_mb(4'h0, 1'b1, 1'b1, rand_tc20(), rand_tc20(), 1'b0, 1'b1, -1, -1);
        chk("start_at_mbdone_ignored_enable", BlockEnable, 0);

        // BlockDone while idle is ignored.
        @(negedge Clk);
        BlockDone = 1'b1; TotalCoeff = 5'd9;
        @(negedge Clk);
        BlockDone = 1'b0;
        chk("idle_done_busy", Busy, 0);
        chk("idle_done_mbdone", MbDone, 0);
        chk("idle_done_enable", BlockEnable, 0);

        for (int r = 0; r < 20; r++)
            run_mb(4'($urandom), 1'($urandom), 1'($urandom), rand_tc20(), rand_tc20(),
                   1'b0, 1'($urandom), -1, -1);

        // Asynchronous reset while block 5 is current.
        @(negedge Clk);
        CbpLuma = 4'hF; LeftAvail = 1'b1; TopAvail = 1'b1;
        LeftTC = rand_tc20(); TopTC = rand_tc20(); Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            BlockDone = 1'b1; TotalCoeff = 5'd16;
            @(negedge Clk);
            BlockDone = 1'b0;
        end
        chk("pre_reset_idx", BlkIdx, 5);
        #2 nReset = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge Clk);
        chk("reset_no_mbdone", MbDone, 0);
        nReset = 1'b1;
        run_mb(4'hF, 1'b0, 1'b0, 20'h0, 20'h0, 1'b0, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
